// File: rtl/fs_timing_gen.sv
// Frame-sync timing generator. It tracks an asynchronous I2S LRCK against
// the master clock and, once the LRCK period matches the selected ratio,
// produces divider strobes aligned to the frame.
module fs_timing_gen #(
  parameter int DIV_W         = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_CNT      = 4,
  parameter int TOL           = 2,
  parameter bit GATE_UNLOCKED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lrck_i,
  input  logic             bck_i,
  input  logic [3:0]       ratio_sel_i,
  output logic [DIV_W:0]   stb_o,
  output logic             fs_stb_o,
  output logic             bck_rise_stb_o,
  output logic             locked_o,
  output logic [DIV_W+1:0] frame_len_o,
  output logic             lock_err_o
);

  localparam int PW = DIV_W + 2;
  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] lr_sync, bk_sync;
  logic                   lr_prev, bk_prev, lr_rise, bk_rise;
  logic [DIV_W-1:0]       div;
  logic [PW-1:0]          pcnt;
  logic [GW-1:0]          gcnt, gcnt_n;
  logic [3:0]             ratio_q;
  logic                   div_clr, err_n, lock_err_q;
  logic                   legal, ratio_chg, good, tmo;
  logic [PW:0]            nom, pc_x;
  logic [PW-1:0]          tmo_lim;
  logic [DIV_W:0]         stb_int;
  logic                   fs_int, gate_ok;

  // Synchronise both I2S clocks, then register a one-cycle rise event.
  always_ff @(posedge clk) begin
    if (rst) begin
      lr_sync <= '0; bk_sync <= '0;
      lr_prev <= 1'b0; bk_prev <= 1'b0;
      lr_rise <= 1'b0; bk_rise <= 1'b0;
    end else begin
      lr_sync <= {lr_sync[SYNC_STAGES-2:0], lrck_i};
      bk_sync <= {bk_sync[SYNC_STAGES-2:0], bck_i};
      lr_prev <= lr_sync[SYNC_STAGES-1];
      bk_prev <= bk_sync[SYNC_STAGES-1];
      lr_rise <= lr_sync[SYNC_STAGES-1] & ~lr_prev;
      bk_rise <= bk_sync[SYNC_STAGES-1] & ~bk_prev;
    end
  end

  // Ratio is sampled so any change can be seen as a one-cycle mismatch;
  // loading it during reset avoids a spurious change right after reset.
  always_ff @(posedge clk) ratio_q <= ratio_sel_i;

  assign ratio_chg = (ratio_q != ratio_sel_i);
  assign legal     = (ratio_q != 4'd0) && (ratio_q <= 4'(DIV_W));
  assign nom       = (PW+1)'(1) << ratio_q;
  assign tmo_lim   = PW'(1) << (ratio_q + 4'd1);
  assign pc_x      = {1'b0, pcnt};
  // pcnt holds the length of the frame that just ended when lr_rise is high.
  assign good      = (pc_x + (PW+1)'(TOL) >= nom) && (pc_x <= nom + (PW+1)'(TOL));
  assign tmo       = (pcnt == tmo_lim);

  // Free-running divider, realigned to the frame by the FSM.
  always_ff @(posedge clk) begin
    if (rst || div_clr) div <= '0;
    else                div <= div + 1'b1;
  end

  // Period counter: saturating, reloads to 1 on each frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= '0;
      frame_len_o <= '0;
    end else if (lr_rise) begin
      pcnt        <= PW'(1);
      frame_len_o <= pcnt;
    end else if (pcnt != '1) begin
      pcnt        <= pcnt + 1'b1;
    end
  end

  // FSM state, good-frame count and lock-loss pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      gcnt       <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state      <= state_n;
      gcnt       <= gcnt_n;
      lock_err_q <= err_n;
    end
  end

  // Next-state logic; ratio changes override frame events, which override timeout.
  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    div_clr = 1'b0;
    err_n   = 1'b0;
    if (!legal || ratio_chg) begin
      state_n = SEARCH;
      gcnt_n  = '0;
      err_n   = (state == LOCKED);
    end else begin
      case (state)
        SEARCH: if (lr_rise) begin
          state_n = MEASURE;
          gcnt_n  = '0;
          div_clr = 1'b1;
        end
        MEASURE: if (lr_rise) begin
          if (good) begin
            gcnt_n = gcnt + 1'b1;
            if (gcnt_n == GW'(LOCK_CNT)) state_n = LOCKED;
          end else begin
            gcnt_n  = '0;
            div_clr = 1'b1;
          end
        end else if (tmo) begin
          state_n = SEARCH;
          gcnt_n  = '0;
        end
        LOCKED: if (lr_rise) begin
          if (!good) begin
            state_n = MEASURE;
            gcnt_n  = '0;
            div_clr = 1'b1;
            err_n   = 1'b1;
          end
        end else if (tmo) begin
          state_n = SEARCH;
          gcnt_n  = '0;
          err_n   = 1'b1;
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  // stb[k] fires when the low k divider bits are all ones.
  assign stb_int[0] = 1'b1;
  for (genvar k = 1; k <= DIV_W; k++) begin : g_stb
    assign stb_int[k] = &div[k-1:0];
  end

  // Frame strobe picks the divider tap for the selected ratio.
  always_comb begin
    fs_int = 1'b0;
    for (int k = 0; k <= DIV_W; k++)
      if (ratio_q == 4'(k)) fs_int = stb_int[k];
  end

  assign locked_o       = (state == LOCKED);
  assign gate_ok        = locked_o | (GATE_UNLOCKED == 1'b0);
  assign stb_o          = gate_ok ? stb_int : '0;
  assign fs_stb_o       = gate_ok & legal & fs_int;
  assign bck_rise_stb_o = gate_ok & bk_rise;
  assign lock_err_o     = lock_err_q;

endmodule

// File: tb/tb_fs_timing_gen.sv
// Bench for fs_timing_gen: random LRCK frame lengths drive a frame-level
// lock model; expected events are queued and a monitor checks them.
module tb_fs_timing_gen;
  localparam int DIV_W = 10, SS = 2, LOCK_CNT = 4, TOL = 2;
  localparam int SAT = (1 << (DIV_W + 2)) - 1;
  localparam int ST_S = 0, ST_M = 1, ST_L = 2;
  localparam int K_LOCK = 1, K_ERR = 2;

  logic clk = 1'b0, rst, lrck, bck;
  logic [3:0] ratio;
  logic [DIV_W:0] stb;
  logic fs, bckr, locked, lerr;
  logic [DIV_W+1:0] flen;

  fs_timing_gen #(.DIV_W(DIV_W), .SYNC_STAGES(SS), .LOCK_CNT(LOCK_CNT),
                  .TOL(TOL), .GATE_UNLOCKED(1'b1)) dut (
    .clk(clk), .rst(rst), .lrck_i(lrck), .bck_i(bck), .ratio_sel_i(ratio),
    .stb_o(stb), .fs_stb_o(fs), .bck_rise_stb_o(bckr), .locked_o(locked),
    .frame_len_o(flen), .lock_err_o(lerr));

  always #5 clk = ~clk;

  int pc = 0;
  always @(posedge clk) pc <= pc + 1;

  int total = 0, bad = 0;
  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, pc, act, exp);
    end
  endtask

  typedef struct { int t; int kind; } evt_t;
  typedef struct { int t; int len; } fl_t;
  evt_t eq[$];
  fl_t  fq[$];
  int   bq[$];

  // Frame-level reference: lock after LOCK_CNT in-tolerance frames, lose it on
  // a bad frame, a silent LRCK or a ratio change. Event times are in cycles
  // after the LRCK edge is driven (sync + edge register + state register).
  int m_state, m_cnt, m_last, m_ratio;

  function automatic bit m_legal();
    return (m_ratio >= 1) && (m_ratio <= DIV_W);
  endfunction

  task automatic model_reset();
    m_state = ST_S; m_cnt = 0; m_last = -1000000;
  endtask

  task automatic model_rise(input int k);
    int len, nom;
    bit g;
    len = (k - m_last > SAT) ? SAT : k - m_last;
    nom = 1 << m_ratio;
    g = (len >= nom - TOL) && (len <= nom + TOL);
    fq.push_back('{k + SS + 2, len});
    m_last = k;
    if (m_legal()) begin
      case (m_state)
        ST_S: begin m_state = ST_M; m_cnt = 0; end
        ST_M: if (g) begin
          m_cnt++;
          if (m_cnt == LOCK_CNT) begin m_state = ST_L; eq.push_back('{k + SS + 2, K_LOCK}); end
        end else m_cnt = 0;
        default: if (!g) begin
          eq.push_back('{k + SS + 2, K_ERR}); m_state = ST_M; m_cnt = 0;
        end
      endcase
    end
  endtask

  task automatic model_stop();
    if (m_state == ST_L) eq.push_back('{m_last + SS + 2 + (1 << (m_ratio + 1)), K_ERR});
    m_state = ST_S; m_cnt = 0;
  endtask

  task automatic model_ratio(input int k, input int r);
    if (m_state == ST_L) eq.push_back('{k + 1, K_ERR});
    m_state = ST_S; m_cnt = 0; m_ratio = r;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One LRCK frame of p cycles; optionally change the ratio chg_at cycles in.
  task automatic frame(input int p, input int chg_at, input int new_r);
    lrck = 1'b1; model_rise(pc);
    if (chg_at > 0) begin
      wait_n(chg_at); ratio = 4'(new_r); model_ratio(pc, new_r); wait_n(p/2 - chg_at);
    end else wait_n(p/2);
    lrck = 1'b0; wait_n(p - p/2);
  endtask

  function automatic int pgood(input int nom);
    return nom - TOL + int'($urandom_range(0, 2*TOL));
  endfunction

  function automatic int pbad(input int nom);
    int d;
    d = 3 + int'($urandom_range(0, 27));
    return ($urandom_range(0, 1) == 0) ? nom - d : nom + d;
  endfunction

  task automatic bck_run(input int n);
    for (int i = 0; i < n; i++) begin
      bck = 1'b1; bq.push_back(pc + SS + 1); wait_n(2);
      bck = 1'b0; wait_n(2);
    end
  endtask

  // Monitor: pops expected events as the DUT presents them.
  logic locked_q = 1'b0;
  int   fs_prev = -1;
  always @(negedge clk) begin
    evt_t e;
    int mask;
    mask = (1 << (m_ratio + 1)) - 1;
    if (eq.size() > 0 && pc > eq[0].t + 2) begin
      e = eq.pop_front(); check("event_missing", pc, e.t);
    end
    if (bq.size() > 0 && pc > bq[0] + 2) check("bck_missing", pc, bq.pop_front());
    if (fq.size() > 0 && pc >= fq[0].t) begin
      check("frame_len_time", pc, fq[0].t);
      check("frame_len", flen, fq[0].len);
      void'(fq.pop_front());
    end
    if (lerr) begin
      if (eq.size() == 0) check("lock_err_spurious", lerr, 0);
      else begin e = eq.pop_front(); check("lock_err_time", pc, (e.kind == K_ERR) ? e.t : -1); end
    end
    if (locked && !locked_q) begin
      if (eq.size() == 0) check("lock_spurious", locked, 0);
      else begin e = eq.pop_front(); check("lock_time", pc, (e.kind == K_LOCK) ? e.t : -1); end
    end
    if (!locked && locked_q) check("unlock_cause", lerr | rst, 1);
    if (!locked) check("gated_outputs", {stb, fs, bckr}, 0);
    if (locked && fs) begin
      check("stb_taps", stb & mask, mask);
      if (fs_prev >= 0) check("fs_period", pc - fs_prev, 1 << m_ratio);
    end
    if (bckr) begin
      if (bq.size() == 0) check("bck_spurious", bckr, 0);
      else check("bck_time", pc, bq.pop_front());
    end
    fs_prev  <= !locked ? -1 : (fs ? pc : fs_prev);
    locked_q <= locked;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: cycle %0d exceeded budget", pc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lrck = 1'b0; bck = 1'b0; ratio = 4'd8; m_ratio = 8; model_reset();
    wait_n(4);
    check("rst_locked", locked, 0); check("rst_lock_err", lerr, 0);
    check("rst_frame_len", flen, 0); check("rst_stb", stb, 0);
    check("rst_fs", fs, 0); check("rst_bck", bckr, 0);
    rst = 1'b0;
    wait_n(5000);                       // first frame length saturates
    for (int i = 0; i < 12; i++) frame(256, 0, 0);
    fork
      for (int i = 0; i < 10; i++) frame(pgood(256), 0, 0);
      begin wait_n(20); bck_run(200); end
    join
    frame(260, 0, 0);                   // out of tolerance: lock lost
    for (int i = 0; i < 6; i++) frame(256, 0, 0);
    frame(258, 0, 0);                   // edge of tolerance: lock kept
    for (int i = 0; i < 3; i++) frame(256, 0, 0);
    for (int i = 0; i < 30; i++)
      frame(($urandom_range(0, 3) == 0) ? pbad(256) : pgood(256), 0, 0);
    for (int i = 0; i < 6; i++) frame(256, 0, 0);
    model_stop(); wait_n(600);          // LRCK stopped: timeout
    for (int i = 0; i < 8; i++) frame(256, 0, 0);
    frame(256, 100, 9);                 // ratio 8 -> 9
    for (int i = 0; i < 8; i++) frame(pgood(512), 0, 0);
    frame(512, 100, 11);                // illegal ratio
    for (int i = 0; i < 6; i++) frame(512, 0, 0);
    frame(512, 100, 8);
    for (int i = 0; i < 8; i++) frame(pgood(256), 0, 0);
    rst = 1'b1; wait_n(1);              // reset while locked
    check("midrst_locked", locked, 0); check("midrst_lock_err", lerr, 0);
    check("midrst_frame_len", flen, 0); check("midrst_stb", stb, 0);
    model_reset(); wait_n(3); rst = 1'b0;
    wait_n(5000);
    for (int i = 0; i < 8; i++) frame(256, 0, 0);
    wait_n(50);
    check("events_left", eq.size(), 0);
    check("bck_left", bq.size(), 0);
    check("frame_len_left", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
